// File: rtl/l2_cache_multi_arb_stage_pkg.sv
// Shared encodings for the L2 front-of-pipe arbiter: packet-type values and defaults.
package l2_cache_multi_arb_stage_pkg;

  localparam int DEFAULT_NUM_REQUESTERS = 4;

  typedef enum logic [1:0] {
    L2_PKT_REQUEST     = 2'd0,
    L2_PKT_IINVALIDATE = 2'd1,
    L2_PKT_FLUSH       = 2'd2,
    L2_PKT_DINVALIDATE = 2'd3
  } l2_pkt_type_e;

  function automatic logic is_invalidate(input logic [1:0] pkt_type);
    return (pkt_type == L2_PKT_IINVALIDATE) || (pkt_type == L2_PKT_DINVALIDATE);
  endfunction

endpackage

// File: rtl/l2_rr_pointer_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer, wrapping,
// and advances the pointer past the winner when the caller commits the grant.
module l2_rr_pointer_arbiter #(
  parameter int NUM_REQUESTERS = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQUESTERS-1:0] request,
  input  logic                      update,
  output logic [NUM_REQUESTERS-1:0] grant_oh
);

  localparam int PW = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;

  logic [PW-1:0] pointer;
  logic [PW-1:0] win_idx;
  logic [PW-1:0] scan_idx;
  logic          found;

  always_comb begin
    grant_oh = '0;
    win_idx  = '0;
    found    = 1'b0;
    scan_idx = pointer;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      if (!found && request[scan_idx]) begin
        grant_oh[scan_idx] = 1'b1;
        win_idx            = scan_idx;
        found              = 1'b1;
      end
      scan_idx = (scan_idx == PW'(NUM_REQUESTERS - 1)) ? '0 : scan_idx + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pointer <= '0;
    end else if (update && found) begin
      pointer <= (win_idx == PW'(NUM_REQUESTERS - 1)) ? '0 : win_idx + PW'(1);
    end
  end

endmodule

// File: rtl/l2_cache_multi_arb_stage.sv
// L2 front-end arbiter: restarts beat cores unless a core has waited out the restart
// streak limit; the winner is registered into a single backpressured output slot.
module l2_cache_multi_arb_stage
  import l2_cache_multi_arb_stage_pkg::*;
#(
  parameter int          NUM_REQUESTERS     = DEFAULT_NUM_REQUESTERS,
  parameter int          REQ_WIDTH          = 96,
  parameter int          LINE_WIDTH         = 512,
  parameter logic [1:0]  FLUSH_TYPE         = L2_PKT_FLUSH,
  parameter int          MAX_RESTART_STREAK = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_REQUESTERS-1:0]           core_valid,
  input  logic [NUM_REQUESTERS*REQ_WIDTH-1:0] core_request,
  output logic [NUM_REQUESTERS-1:0]           core_ready,
  input  logic                                restart_valid,
  input  logic [REQ_WIDTH-1:0]                restart_request,
  input  logic [LINE_WIDTH-1:0]               restart_data,
  input  logic                                restart_collided,
  output logic                                restart_ready,
  input  logic                                bus_stall,
  output logic                                out_valid,
  output logic [REQ_WIDTH-1:0]                out_request,
  output logic [LINE_WIDTH-1:0]               out_data,
  output logic                                out_is_fill,
  output logic                                out_is_restarted_flush,
  input  logic                                out_ready,
  output logic                                starve_override
);

  localparam int SW = (MAX_RESTART_STREAK > 0) ? $clog2(MAX_RESTART_STREAK + 1) : 1;

  logic                      slot_free;
  logic                      any_core;
  logic                      force_grant;
  logic                      core_grant;
  logic [NUM_REQUESTERS-1:0] grant_oh;
  logic [REQ_WIDTH-1:0]      core_sel;
  logic [SW-1:0]             streak;
  logic [1:0]                restart_type;

  assign slot_free     = !out_valid || out_ready;
  assign any_core      = |core_valid;
  assign restart_type  = restart_request[1:0];
  assign force_grant   = (MAX_RESTART_STREAK != 0) && (streak == SW'(MAX_RESTART_STREAK)) && any_core;
  assign restart_ready = slot_free && restart_valid && !force_grant;
  // bus_stall only gates core traffic; restarts must drain to release bus resources.
  assign core_grant    = slot_free && any_core && !bus_stall && (!restart_valid || force_grant);
  assign core_ready    = core_grant ? grant_oh : '0;

  l2_rr_pointer_arbiter #(
    .NUM_REQUESTERS(NUM_REQUESTERS)
  ) u_rr_arb (
    .clk     (clk),
    .reset   (reset),
    .request (core_valid),
    .update  (core_grant),
    .grant_oh(grant_oh)
  );

  always_comb begin
    core_sel = '0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      if (grant_oh[i]) begin
        core_sel = core_request[i*REQ_WIDTH +: REQ_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid              <= 1'b0;
      out_request            <= '0;
      out_data               <= '0;
      out_is_fill            <= 1'b0;
      out_is_restarted_flush <= 1'b0;
      starve_override        <= 1'b0;
    end else begin
      starve_override <= core_grant && restart_valid;
      if (slot_free) begin
        out_valid <= restart_ready || core_grant;
      end
      if (restart_ready) begin
        out_request            <= restart_request;
        out_data               <= restart_data;
        out_is_fill            <= !restart_collided && (restart_type != FLUSH_TYPE);
        out_is_restarted_flush <= (restart_type == FLUSH_TYPE);
      end else if (core_grant) begin
        out_request            <= core_sel;
        out_data               <= '0;
        out_is_fill            <= 1'b0;
        out_is_restarted_flush <= 1'b0;
      end
    end
  end

  // Counts restarts that overtook a waiting core; saturates at the limit to force a core grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      streak <= '0;
    end else if (!any_core || core_grant) begin
      streak <= '0;
    end else if (restart_ready && (streak < SW'(MAX_RESTART_STREAK))) begin
      streak <= streak + SW'(1);
    end
  end

  a_core_ready_onehot0 : assert property (@(posedge clk) disable iff (!reset) $onehot0(core_ready));
  a_single_winner : assert property (@(posedge clk) disable iff (!reset) !(restart_ready && |core_ready));
  a_restart_not_inval : assert property (@(posedge clk) disable iff (!reset)
    restart_valid |-> !is_invalidate(restart_type));

endmodule

// File: doc/l2_cache_multi_arb_stage.md
Name: l2_cache_multi_arb_stage

Overview:
Parametrised L2 request arbiter for the front of the L2 pipeline. It selects among NUM_REQUESTERS core request channels and one restarted-request channel from the L2 bus interface, and registers the winner into an output slot. Unlike the previous-generation arbiter, it honours downstream backpressure from the tag stage. It also provides a ready handshake on the restart channel and bounds core starvation with a configurable restart-streak limit.

Parameters:
NUM_REQUESTERS, 4, number of core request channels (1..16)
REQ_WIDTH, 96, bits in one request packet (opaque payload; bits [1:0] = packet type)
LINE_WIDTH, 512, bits in a cache line of fill data
FLUSH_TYPE, 2'd2, packet-type encoding marking a flush request
MAX_RESTART_STREAK, 8, consecutive restart grants allowed while a core waits; 0 disables the limit

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset (asserted when 0)
core_valid  in  NUM_REQUESTERS  per-core request valid; must not depend on core_ready
core_request  in  NUM_REQUESTERS*REQ_WIDTH  packed per-core packets; core i occupies [i*REQ_WIDTH +: REQ_WIDTH]
core_ready  out  NUM_REQUESTERS  one-hot; core i accepted this cycle
restart_valid  in  1  restarted request from bus interface; held until accepted
restart_request  in  REQ_WIDTH  restarted packet
restart_data  in  LINE_WIDTH  fill line accompanying restart
restart_collided  in  1  restart is a collided miss, not a fill
restart_ready  out  1  restart accepted this cycle
bus_stall  in  1  bus interface requests no new core traffic
out_valid  out  1  output slot holds a request
out_request  out  REQ_WIDTH  registered packet
out_data  out  LINE_WIDTH  registered fill line
out_is_fill  out  1  restart, not collided, not a flush
out_is_restarted_flush  out  1  restart whose type equals FLUSH_TYPE
out_ready  in  1  tag stage consumes the slot this cycle
starve_override  out  1  registered pulse; the previous load was a forced core grant

Behaviour:
- Reset (reset=0, asynchronous) clears out_valid, starve_override, the streak counter, and the RR pointer (points to core 0). out_request, out_data, out_is_fill and out_is_restarted_flush reset to 0.
- Slot-free condition: slot_free = !out_valid || out_ready. Loading is combinational; there is no combinational path from core_ready back to core_valid.
- Forced grant: force = (MAX_RESTART_STREAK != 0) && streak == MAX_RESTART_STREAK && |core_valid.
- Restart acceptance: restart_ready = slot_free && restart_valid && !force. Restart loads ignore bus_stall.
- Core acceptance: core_grant = slot_free && |core_valid && !bus_stall && (!restart_valid || force).
- Priority: the core winner is the first valid core at or after the RR pointer, wrapping from NUM_REQUESTERS-1 to 0. On a core grant to core k, the pointer moves to (k+1) mod NUM_REQUESTERS. The pointer is unchanged on restart grants and on idle cycles.
- Latency: the accepted request appears on out_* one cycle after acceptance. out_valid stays at 1 with contents frozen while out_ready=0.
- Slot emptying: if slot_free and nothing is accepted, out_valid goes to 0 on the next edge.
- Flags:
  - out_is_fill = !restart_collided && type != FLUSH_TYPE for restart loads; 0 for core loads.
  - out_is_restarted_flush = (type == FLUSH_TYPE) for restart loads; 0 for core loads.
- Streak counter (width clog2(MAX_RESTART_STREAK+1), saturating):
  - Increments on a restart grant while |core_valid.
  - Clears on any core grant, and on any cycle where core_valid == 0.
  - Otherwise holds.
- starve_override <= core_grant && restart_valid (1 only for forced grants).
- Simultaneous out_ready and a new accept replace the slot in the same cycle, giving full throughput.
- When force is active but bus_stall=1, no one is granted. Restart remains blocked until the force resolves, or until core_valid drops and clears the streak.
- Assertions (simulation only):
  - core_ready is one-hot0.
  - restart_ready and |core_ready are never both 1.
  - restart type is not an invalidate encoding.

Decomposition:
- defines.sv gains L2 arbiter type encodings (FLUSH/IINVALIDATE/DINVALIDATE) and the default NUM_REQUESTERS.
- One natural sub-module: l2_rr_pointer_arbiter. It takes request vector and update, returns grant_oh, and holds the pointer with the same asynchronous active-low reset. Index conversion is inline.

Test Plan:
- Reset mid-traffic: assert reset=0 with out_valid=1 -> out_valid=0 and starve_override=0 immediately (asynchronous); after release, the first grant goes to core 0 when all cores are valid.
- Round-robin fairness: NUM_REQUESTERS=4, all core_valid=1, out_ready=1 for 8 cycles -> grants 0,1,2,3,0,1,2,3; out_valid=1 every cycle from cycle 1.
- Restart priority and flags:
  - restart_valid with core 2 valid, type=FLUSH_TYPE -> restart_ready=1, core_ready=0; next cycle out_is_restarted_flush=1, out_is_fill=0.
  - restart with restart_collided=0 and a non-flush type -> out_is_fill=1.
- Starvation limit: MAX_RESTART_STREAK=3, restart_valid held high, core 1 valid -> 3 restart grants, then core_ready[1]=1; starve_override=1 one cycle later; the restart is granted the cycle after.
- Backpressure: out_ready=0 for 5 cycles with core 0 valid -> out_* frozen, core_ready=0 throughout; out_ready=1 -> slot replaced in the same cycle.
- bus_stall: bus_stall=1 with core 3 valid and no restart -> no core grant, out_valid drops to 0; a concurrent restart_valid is still accepted.
